uart_ram_host: RTL and testbench

Host-side UART initiator for the `uart_ram` command protocol. It accepts parallel write/read requests, serializes them onto `txd` as the command, address and data frames `uart_ram` expects, and, for reads, deserializes the one-byte response returned on `rxd`. It sits in the host FPGA or in bench infrastructure, directly facing a `uart_ram` instance at the same bit rate.

---
 rtl/uart_ram_host.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_ram_host.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_host.sv
// ---------------------------------------------------------------------------
// uart_ram_host
//   Host-side UART initiator for the uart_ram command protocol. Parallel
//   write/read requests are serialized on txd as command/address(/data)
//   frames (8N1, LSB first). For reads, the one-byte response on rxd is
//   deserialized into rd_data.
//
// Ports
//   sys_clk      : single clock
//   rst_n        : asynchronous active-low reset
//   cmd_valid    : request present
//   cmd_ready    : block is IDLE and can accept a request
//   cmd_we       : 1 = write, 0 = read
//   cmd_addr     : RAM address
//   cmd_wdata    : write data (ignored for reads)
//   done         : one-cycle pulse on successful completion
//   rd_valid     : one-cycle pulse when rd_data is updated
//   rd_data      : last successfully read byte
//   err_timeout  : one-cycle pulse when no read response starts in time
//   err_frame    : one-cycle pulse when the response stop bit is 0
//   busy         : high whenever the block is not IDLE
//   txd          : serial out, idle high
//   rxd          : serial in, asynchronous
// ---------------------------------------------------------------------------
module uart_ram_host #(
    parameter int unsigned CLKS_PER_BIT = 64,
    parameter int unsigned TIMEOUT_BITS = 32,
    parameter logic [7:0]  CMD_W        = 8'hF0,
    parameter logic [7:0]  CMD_R        = 8'h0F
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       done,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       err_timeout,
    output logic       err_frame,
    output logic       busy,
    output logic       txd,
    input  logic       rxd
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_START,
        S_TX_DATA,
        S_TX_STOP,
        S_RX_WAIT,
        S_RX_START,
        S_RX_DATA,
        S_RX_STOP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_idx;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_to_cnt;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_rx_shift;
    logic        r_we;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_s3;
    logic        r_done;
    logic        r_rd_valid;
    logic        r_err_timeout;
    logic        r_err_frame;
    logic [7:0]  r_rd_data;

    logic        w_bit_end;
    logic        w_half;
    logic        w_to_end;
    logic        w_last_bit;
    logic        w_last_byte;
    logic        w_rx_fall;
    logic [7:0]  w_tx_byte;
    logic        w_done_n;
    logic        w_rdv_n;
    logic        w_eto_n;
    logic        w_efr_n;
    logic        w_txd;

    assign w_bit_end   = (r_clk_cnt == BIT_LAST);
    assign w_half      = (r_clk_cnt == HALF_LAST);
    assign w_to_end    = (r_to_cnt == TO_LAST);
    assign w_last_bit  = (r_bit_idx == 3'd7);
    assign w_last_byte = r_we ? (r_byte_idx == 2'd2) : (r_byte_idx == 2'd1);
    // Falling edge of the synchronized rxd (s3 is the previous s2 value).
    assign w_rx_fall   = r_rx_s3 & ~r_rx_s2;

    always_comb begin
        w_tx_byte = r_wdata;
        case (r_byte_idx)
            2'd0:    w_tx_byte = r_we ? CMD_W : CMD_R;
            2'd1:    w_tx_byte = r_addr;
            default: w_tx_byte = r_wdata;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and completion/error pulse decode
    always_comb begin
        w_next   = r_state;
        w_done_n = 1'b0;
        w_rdv_n  = 1'b0;
        w_eto_n  = 1'b0;
        w_efr_n  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_next = S_TX_START;
            end
            S_TX_START: begin
                if (w_bit_end) w_next = S_TX_DATA;
            end
            S_TX_DATA: begin
                if (w_bit_end && w_last_bit) w_next = S_TX_STOP;
            end
            S_TX_STOP: begin
                if (w_bit_end) begin
                    if (!w_last_byte) begin
                        w_next = S_TX_START;
                    end else if (r_we) begin
                        w_next   = S_IDLE;
                        w_done_n = 1'b1;
                    end else begin
                        w_next = S_RX_WAIT;
                    end
                end
            end
            S_RX_WAIT: begin
                if (w_to_end) begin
                    w_next  = S_IDLE;
                    w_eto_n = 1'b1;
                end else if (w_rx_fall) begin
                    w_next = S_RX_START;
                end
            end
            S_RX_START: begin
                if (w_to_end) begin
                    w_next  = S_IDLE;
                    w_eto_n = 1'b1;
                end else if (w_half) begin
                    w_next = r_rx_s2 ? S_RX_WAIT : S_RX_DATA;
                end
            end
            S_RX_DATA: begin
                if (w_bit_end && w_last_bit) w_next = S_RX_STOP;
            end
            S_RX_STOP: begin
                if (w_bit_end) begin
                    w_next = S_IDLE;
                    if (r_rx_s2) begin
                        w_done_n = 1'b1;
                        w_rdv_n  = 1'b1;
                    end else begin
                        w_efr_n = 1'b1;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_cnt     <= '0;
            r_bit_idx     <= '0;
            r_byte_idx    <= '0;
            r_to_cnt      <= '0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rx_s1       <= 1'b1;
            r_rx_s2       <= 1'b1;
            r_rx_s3       <= 1'b1;
            r_done        <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_frame   <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;

            if (r_state == S_IDLE || r_state == S_RX_WAIT)
                r_clk_cnt <= '0;
            else if (w_next != r_state || w_bit_end)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + 16'd1;

            // Timeout runs through RX_WAIT and RX_START (including glitch
            // returns to RX_WAIT) and is cleared everywhere else.
            if (r_state == S_RX_WAIT || r_state == S_RX_START)
                r_to_cnt <= r_to_cnt + 32'd1;
            else
                r_to_cnt <= '0;

            if (r_state == S_IDLE) begin
                r_bit_idx  <= '0;
                r_byte_idx <= '0;
                if (cmd_valid) begin
                    r_we    <= cmd_we;
                    r_addr  <= cmd_addr;
                    r_wdata <= cmd_wdata;
                end
            end

            if (r_state == S_TX_START && w_bit_end)
                r_tx_shift <= w_tx_byte;

            if (r_state == S_TX_DATA && w_bit_end) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_bit_idx  <= r_bit_idx + 3'd1;
            end

            if (r_state == S_TX_STOP && w_bit_end)
                r_byte_idx <= r_byte_idx + 2'd1;

            if (r_state == S_RX_DATA && w_bit_end) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_bit_idx  <= r_bit_idx + 3'd1;
            end

            if (w_rdv_n)
                r_rd_data <= r_rx_shift;

            r_done        <= w_done_n;
            r_rd_valid    <= w_rdv_n;
            r_err_timeout <= w_eto_n;
            r_err_frame   <= w_efr_n;
        end
    end

    // txd is decoded from the state register so reset forces it high at once.
    always_comb begin
        w_txd = 1'b1;
        case (r_state)
            S_TX_START: w_txd = 1'b0;
            S_TX_DATA:  w_txd = r_tx_shift[0];
            default:    w_txd = 1'b1;
        endcase
    end

    assign txd         = w_txd;
    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign err_timeout = r_err_timeout;
    assign err_frame   = r_err_frame;

endmodule

// File: tb/tb_uart_ram_host.sv
// ---------------------------------------------------------------------------
// tb_uart_ram_host
//   Directed self-checking bench for uart_ram_host: write, read, timeout,
//   frame error, rxd glitch with ignored cmd_valid, and mid-transaction reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_ram_host;

    localparam int CPB = 64;
    localparam int TOB = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       done;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       err_timeout;
    logic       err_frame;
    logic       busy;
    logic       txd;
    logic       rxd = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_done = 0, n_rdv = 0, n_eto = 0, n_efr = 0, n_both = 0;
    int last_done_cyc = 0;
    int fall_cyc = 0;

    uart_ram_host #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB),
        .CMD_W(8'hF0),
        .CMD_R(8'h0F)
    ) dut (
        .sys_clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we(cmd_we),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .done(done),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .err_timeout(err_timeout),
        .err_frame(err_frame),
        .busy(busy),
        .txd(txd),
        .rxd(rxd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts high cycles of each status output.
    always @(negedge clk) begin
        if (done) begin
            n_done <= n_done + 1;
            last_done_cyc <= cyc;
        end
        if (rd_valid)         n_rdv  <= n_rdv + 1;
        if (err_timeout)      n_eto  <= n_eto + 1;
        if (err_frame)        n_efr  <= n_efr + 1;
        if (done && rd_valid) n_both <= n_both + 1;
    end

    // Present a request for one cycle; returns #1 after the accept edge.
    task automatic do_accept(input logic we, input logic [7:0] a, input logic [7:0] d,
                             output int acc);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    // Capture one 8N1 frame from txd, sampling each bit near its centre.
    task automatic get_frame(output logic [7:0] b, output logic stp, output logic ok);
        int n;
        n = 0;
        b = 8'h00;
        stp = 1'b0;
        while (txd !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        ok = (txd === 1'b0);
        repeat (CPB / 2) @(negedge clk);
        if (txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        stp = txd;
    endtask

    // Drive one response frame onto rxd.
    task automatic send_byte(input logic [7:0] b, input logic stopb);
        @(posedge clk);
        #1;
        rxd = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rxd = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rxd = stopb;
        repeat (CPB) @(posedge clk);
        #1 rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl txd=%b ready=%b busy=%b exp 1 1 0", txd, cmd_ready, busy);
        end
        checks++;
        if (done !== 1'b0 || rd_valid !== 1'b0 || err_timeout !== 1'b0 || err_frame !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses done=%b rdv=%b eto=%b efr=%b exp 0000",
                     done, rd_valid, err_timeout, err_frame);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd_data got=%h exp=00", rd_data);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        int acc, n, d0, r0;
        logic [7:0] b;
        logic s, ok;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hF0; exp_b[1] = 8'h05; exp_b[2] = 8'hCA;
        d0 = n_done; r0 = n_rdv;
        do_accept(1'b1, 8'h05, 8'hCA, acc);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || txd !== 1'b0) begin
            failures++;
            $display("FAIL wr_start busy=%b ready=%b txd=%b exp 1 0 0", busy, cmd_ready, txd);
        end
        for (int f = 0; f < 3; f++) begin
            get_frame(b, s, ok);
            checks++;
            if (!ok || b !== exp_b[f] || s !== 1'b1) begin
                failures++;
                $display("FAIL wr_frame%0d got=%h stop=%b ok=%b exp=%h stop=1", f, b, s, ok, exp_b[f]);
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || (cyc - acc) != 30 * CPB) begin
            failures++;
            $display("FAIL wr_done_time done=%b delta=%0d exp=%0d", done, cyc - acc, 30 * CPB);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_idle ready=%b busy=%b exp 1 0", cmd_ready, busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n_done - d0 != 1 || n_rdv - r0 != 0) begin
            failures++;
            $display("FAIL wr_counts done=%0d rdv=%0d exp 1 0", n_done - d0, n_rdv - r0);
        end
    endtask

    task automatic test_read();
        int acc, d0, r0, b0, e0;
        logic [7:0] b;
        logic s, ok;
        d0 = n_done; r0 = n_rdv; b0 = n_both; e0 = n_eto + n_efr;
        do_accept(1'b0, 8'h05, 8'h99, acc);
        get_frame(b, s, ok);
        checks++;
        if (!ok || b !== 8'h0F || s !== 1'b1) begin
            failures++;
            $display("FAIL rd_cmd_frame got=%h stop=%b ok=%b exp=0f", b, s, ok);
        end
        get_frame(b, s, ok);
        checks++;
        if (!ok || b !== 8'h05 || s !== 1'b1) begin
            failures++;
            $display("FAIL rd_addr_frame got=%h stop=%b ok=%b exp=05", b, s, ok);
        end
        repeat (CPB / 2 + 3 * CPB) @(posedge clk);
        send_byte(8'hCA, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (n_done - d0 != 1 || n_rdv - r0 != 1 || n_both - b0 != 1 || (n_eto + n_efr) != e0) begin
            failures++;
            $display("FAIL rd_pulses done=%0d rdv=%0d both=%0d err=%0d exp 1 1 1 0",
                     n_done - d0, n_rdv - r0, n_both - b0, n_eto + n_efr - e0);
        end
        checks++;
        if (rd_data !== 8'hCA) begin
            failures++;
            $display("FAIL rd_data got=%h exp=ca", rd_data);
        end
        // Stop-bit sample lands about 9.5 bit periods plus synchronizer delay
        // after the falling edge.
        checks++;
        if ((last_done_cyc - fall_cyc) < 608 || (last_done_cyc - fall_cyc) > 614) begin
            failures++;
            $display("FAIL rd_latency got=%0d exp=608..614", last_done_cyc - fall_cyc);
        end
    endtask

    task automatic test_timeout();
        int acc, n, d0;
        logic [7:0] b;
        logic s, ok;
        d0 = n_done;
        do_accept(1'b0, 8'h33, 8'h00, acc);
        get_frame(b, s, ok);
        get_frame(b, s, ok);
        checks++;
        if (!ok || b !== 8'h33) begin
            failures++;
            $display("FAIL to_addr_frame got=%h ok=%b exp=33", b, ok);
        end
        n = 0;
        while (err_timeout !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (err_timeout !== 1'b1 || (cyc - acc) != 20 * CPB + TOB * CPB) begin
            failures++;
            $display("FAIL to_time eto=%b delta=%0d exp=%0d", err_timeout, cyc - acc, 20 * CPB + TOB * CPB);
        end
        checks++;
        if (cmd_ready !== 1'b1 || rd_data !== 8'hCA || n_done != d0) begin
            failures++;
            $display("FAIL to_state ready=%b rd_data=%h dn=%0d exp 1 ca 0", cmd_ready, rd_data, n_done - d0);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_frame_err();
        int acc, d0, r0, f0, t0;
        logic [7:0] b;
        logic s, ok;
        d0 = n_done; r0 = n_rdv; f0 = n_efr; t0 = n_eto;
        do_accept(1'b0, 8'h21, 8'h00, acc);
        get_frame(b, s, ok);
        get_frame(b, s, ok);
        repeat (CPB) @(posedge clk);
        send_byte(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (n_efr - f0 != 1 || n_rdv != r0 || n_done != d0 || n_eto != t0) begin
            failures++;
            $display("FAIL fe_pulses efr=%0d rdv=%0d done=%0d eto=%0d exp 1 0 0 0",
                     n_efr - f0, n_rdv - r0, n_done - d0, n_eto - t0);
        end
        checks++;
        if (rd_data !== 8'hCA || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL fe_rd_data got=%h ready=%b exp ca 1", rd_data, cmd_ready);
        end
    endtask

    task automatic test_glitch();
        int acc, d0, r0, e0;
        logic [7:0] b;
        logic s, ok;
        d0 = n_done; r0 = n_rdv; e0 = n_eto + n_efr;
        do_accept(1'b0, 8'h44, 8'h00, acc);
        get_frame(b, s, ok);
        get_frame(b, s, ok);
        repeat (CPB / 2 + CPB) @(posedge clk);
        #1 rxd = 1'b0;
        repeat (10) @(posedge clk);
        #1 rxd = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 8'h77;
        cmd_wdata = 8'h66;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (CPB) @(posedge clk);
        checks++;
        if (busy !== 1'b1 || txd !== 1'b1) begin
            failures++;
            $display("FAIL gl_waiting busy=%b txd=%b exp 1 1", busy, txd);
        end
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (rd_data !== 8'hA5 || n_done - d0 != 1 || n_rdv - r0 != 1 || (n_eto + n_efr) != e0) begin
            failures++;
            $display("FAIL gl_result rd_data=%h done=%0d rdv=%0d err=%0d exp a5 1 1 0",
                     rd_data, n_done - d0, n_rdv - r0, n_eto + n_efr - e0);
        end
        repeat (200) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || txd !== 1'b1 || n_done - d0 != 1) begin
            failures++;
            $display("FAIL gl_no_extra busy=%b txd=%b done=%0d exp 0 1 1", busy, txd, n_done - d0);
        end
    endtask

    task automatic test_reset_mid();
        int acc, d0, n;
        logic [7:0] b;
        logic s, ok;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hF0; exp_b[1] = 8'h07; exp_b[2] = 8'h5A;
        d0 = n_done;
        do_accept(1'b1, 8'h09, 8'h11, acc);
        // 10 cycles into the start bit of the data frame.
        repeat (20 * CPB + 9) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rm_pre txd=%b busy=%b exp 0 1", txd, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rm_async txd=%b busy=%b ready=%b exp 1 0 1", txd, busy, cmd_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        checks++;
        if (n_done != d0 || txd !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rm_aborted done=%0d txd=%b busy=%b exp 0 1 0", n_done - d0, txd, busy);
        end
        do_accept(1'b1, 8'h07, 8'h5A, acc);
        for (int f = 0; f < 3; f++) begin
            get_frame(b, s, ok);
            checks++;
            if (!ok || b !== exp_b[f] || s !== 1'b1) begin
                failures++;
                $display("FAIL rm_frame%0d got=%h stop=%b ok=%b exp=%h", f, b, s, ok, exp_b[f]);
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || (cyc - acc) != 30 * CPB) begin
            failures++;
            $display("FAIL rm_done done=%b delta=%0d exp=%0d", done, cyc - acc, 30 * CPB);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
